// File: rtl/dot_acc_8bit.sv
// Streaming dot-product accumulator: sums LEN unsigned 16-bit products per vector
// and presents each completed sum in a one-entry output slot with a valid/ready handshake.
module dot_acc_8bit #(
    parameter int LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    input  logic [15:0] in_data,
    input  logic        clr,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [19:0] out_sum,
    output logic        busy,
    output logic        ovf_err
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_t;

    localparam logic [3:0] LAST_BEAT = 4'(LEN - 1);

    logic [3:0]  r_cnt;
    logic [19:0] r_acc;
    logic [19:0] r_sum;
    logic        r_busy;
    logic        r_ovf;
    slot_t       r_slot;

    logic        w_beat;
    logic        w_last;
    logic        w_accept;
    logic        w_drop;
    logic        w_release;
    logic [19:0] w_next;
    logic [3:0]  w_cnt_next;
    logic [19:0] w_acc_next;

    // clr suppresses the beat entirely, so it can never complete a vector.
    assign w_beat    = in_vld && !clr;
    assign w_last    = w_beat && (r_cnt == LAST_BEAT);
    assign w_next    = (r_cnt == 4'd0) ? 20'(in_data) : r_acc + 20'(in_data);
    assign w_accept  = w_last && ((r_slot == SLOT_EMPTY) || out_rdy);
    assign w_drop    = w_last && (r_slot == SLOT_FULL) && !out_rdy;
    assign w_release = !w_last && (r_slot == SLOT_FULL) && out_rdy;

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        w_cnt_next = r_cnt;
        w_acc_next = r_acc;
        if (clr) begin
            w_cnt_next = 4'd0;
            w_acc_next = 20'd0;
        end else if (w_last) begin
            w_cnt_next = 4'd0;
            w_acc_next = 20'd0;
        end else if (w_beat) begin
            w_cnt_next = r_cnt + 4'd1;
            w_acc_next = w_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 4'd0;
            r_acc  <= 20'd0;
            r_sum  <= 20'd0;
            r_busy <= 1'b0;
            r_ovf  <= 1'b0;
            r_slot <= SLOT_EMPTY;
        end else begin
            r_cnt  <= w_cnt_next;
            r_acc  <= w_acc_next;
            r_busy <= (w_cnt_next != 4'd0);

            if (clr) begin
                r_ovf <= 1'b0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
            end

            if (w_accept) begin
                r_sum  <= w_next;
                r_slot <= SLOT_FULL;
            end else if (w_release) begin
                r_slot <= SLOT_EMPTY;
            end
        end
    end

    assign out_vld = (r_slot == SLOT_FULL);
    assign out_sum = r_sum;
    assign busy    = r_busy;
    assign ovf_err = r_ovf;

endmodule

// File: tb/tb_dot_acc_8bit.sv
// Bench for dot_acc_8bit: three instances (LEN=4,2,1) share one stimulus stream and are
// compared every cycle against a beat-list reference model, plus directed spot checks.
module tb_dot_acc_8bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [15:0] in_data;
    logic        clr;
    logic        out_rdy;

    logic        w_vld  [3];
    logic [19:0] w_sum  [3];
    logic        w_busy [3];
    logic        w_ovf  [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dot_acc_8bit #(.LEN(4)) u_len4 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .clr(clr),
        .out_vld(w_vld[0]), .out_rdy(out_rdy), .out_sum(w_sum[0]),
        .busy(w_busy[0]), .ovf_err(w_ovf[0])
    );

    dot_acc_8bit #(.LEN(2)) u_len2 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .clr(clr),
        .out_vld(w_vld[1]), .out_rdy(out_rdy), .out_sum(w_sum[1]),
        .busy(w_busy[1]), .ovf_err(w_ovf[1])
    );

    dot_acc_8bit #(.LEN(1)) u_len1 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .clr(clr),
        .out_vld(w_vld[2]), .out_rdy(out_rdy), .out_sum(w_sum[2]),
        .busy(w_busy[2]), .ovf_err(w_ovf[2])
    );

    // Reference model: the beats of the open vector are kept as a list and summed on completion.
    int unsigned m_beats [3][16];
    int          m_nb    [3];
    bit          m_full  [3];
    int unsigned m_val   [3];
    bit          m_ovf   [3];

    function automatic int len_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            bit          done;
            int unsigned s;
            done = 1'b0;
            s    = 0;
            if (rst) begin
                m_nb[k]   = 0;
                m_full[k] = 1'b0;
                m_val[k]  = 0;
                m_ovf[k]  = 1'b0;
            end else begin
                if (clr) begin
                    m_nb[k]  = 0;
                    m_ovf[k] = 1'b0;
                end else if (in_vld) begin
                    m_beats[k][m_nb[k]] = in_data;
                    m_nb[k]++;
                    if (m_nb[k] == len_of(k)) begin
                        for (int i = 0; i < len_of(k); i++) s += m_beats[k][i];
                        done    = 1'b1;
                        m_nb[k] = 0;
                    end
                end
                if (done) begin
                    if (!m_full[k] || out_rdy) begin
                        m_full[k] = 1'b1;
                        m_val[k]  = s;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                end else if (m_full[k] && out_rdy) begin
                    m_full[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("len%0d out_vld", len_of(k)), 32'(w_vld[k]),  32'(m_full[k]));
            check($sformatf("len%0d out_sum", len_of(k)), 32'(w_sum[k]),  m_val[k]);
            check($sformatf("len%0d busy",    len_of(k)), 32'(w_busy[k]), 32'(m_nb[k] != 0));
            check($sformatf("len%0d ovf_err", len_of(k)), 32'(w_ovf[k]),  32'(m_ovf[k]));
        end
    endtask

    task automatic put(input bit v, input int unsigned d, input bit c);
        in_vld  = v;
        in_data = 16'(d);
        clr     = c;
        cycle();
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_data = 16'd0; clr = 1'b0; out_rdy = 1'b1;
        cycle();
        cycle();
        check("reset out_vld", 32'(w_vld[0]), 32'd0);
        check("reset out_sum", 32'(w_sum[0]), 32'd0);
        rst = 1'b0;

        // Four consecutive beats, output valid for exactly one cycle.
        put(1, 100, 0); check("beat1 busy", 32'(w_busy[0]), 32'd1);
        put(1, 200, 0); check("beat2 busy", 32'(w_busy[0]), 32'd1);
        put(1, 300, 0); check("beat3 busy", 32'(w_busy[0]), 32'd1);
        put(1, 400, 0);
        check("vec1000 vld", 32'(w_vld[0]), 32'd1);
        check("vec1000 sum", 32'(w_sum[0]), 32'd1000);
        check("vec1000 busy", 32'(w_busy[0]), 32'd0);
        put(0, 0, 0);
        check("vec1000 one cycle", 32'(w_vld[0]), 32'd0);

        // Maximum products with idle gaps.
        for (int b = 0; b < 4; b++) begin
            put(1, 65025, 0);
            if (b < 3) begin
                put(0, 0, 0); put(0, 0, 0);
                check("gap busy", 32'(w_busy[0]), 32'd1);
            end
        end
        check("max sum", 32'(w_sum[0]), 32'd260100);
        check("max ovf", 32'(w_ovf[0]), 32'd0);
        put(0, 0, 0);

        // Drop while FULL and stalled (LEN=2).
        put(0, 0, 1);
        out_rdy = 1'b0;
        put(1, 1, 0); put(1, 2, 0);
        check("len2 first sum", 32'(w_sum[1]), 32'd3);
        put(1, 3, 0); put(1, 4, 0);
        check("len2 held sum", 32'(w_sum[1]), 32'd3);
        check("len2 ovf set", 32'(w_ovf[1]), 32'd1);
        out_rdy = 1'b1;
        put(0, 0, 0);
        check("len2 drained", 32'(w_vld[1]), 32'd0);
        check("len2 sum held empty", 32'(w_sum[1]), 32'd3);

        // Completion in the same cycle as a handshake (LEN=2).
        put(0, 0, 1);
        out_rdy = 1'b0;
        put(1, 1, 0); put(1, 2, 0);
        put(1, 5, 0);
        out_rdy = 1'b1;
        put(1, 6, 0);
        check("len2 back-to-back vld", 32'(w_vld[1]), 32'd1);
        check("len2 back-to-back sum", 32'(w_sum[1]), 32'd11);
        check("len2 back-to-back ovf", 32'(w_ovf[1]), 32'd0);
        put(0, 0, 0);

        // clr aborts a partial vector and discards the simultaneous beat.
        put(0, 0, 1);
        put(1, 10, 0); put(1, 20, 0);
        put(1, 30, 1);
        check("clr busy", 32'(w_busy[0]), 32'd0);
        put(1, 1, 0); put(1, 2, 0); put(1, 3, 0); put(1, 4, 0);
        check("after clr sum", 32'(w_sum[0]), 32'd10);
        check("after clr ovf", 32'(w_ovf[0]), 32'd0);
        put(0, 0, 0);

        // Reset mid-vector with a pending output.
        out_rdy = 1'b0;
        put(1, 1, 0); put(1, 2, 0); put(1, 3, 0); put(1, 4, 0);
        put(1, 7, 0); put(1, 7, 0); put(1, 7, 0);
        rst = 1'b1;
        put(0, 0, 0);
        check("rst vld", 32'(w_vld[0]), 32'd0);
        check("rst sum", 32'(w_sum[0]), 32'd0);
        check("rst busy", 32'(w_busy[0]), 32'd0);
        check("rst ovf", 32'(w_ovf[0]), 32'd0);
        rst = 1'b0;
        out_rdy = 1'b1;
        put(1, 5, 0); put(1, 5, 0); put(1, 5, 0); put(1, 5, 0);
        check("post-rst sum", 32'(w_sum[0]), 32'd20);
        check("len1 sum", 32'(w_sum[2]), 32'd5);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            put(($urandom_range(0, 3) != 0), $urandom_range(0, 65025), ($urandom_range(0, 29) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
